mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one single-port synchronous data RAM between two bus masters. m0 is the cpu load/store port; m1 is the program loader/debug port.
- Each master uses the cpu memory signalling (read, write, address, dout, din) plus a one-cycle ready pulse that acknowledges completion.
- Requests are granted round-robin. Each transaction is sequenced through a fixed state machine that handles the RAM read latency.

Parameters:
- AW, 32, address width
- DW, 32, data width
- RD_LAT, 1, cycles from the ram_en cycle to ram_rdata valid; legal range 1..15

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- m0_read  in  1  master 0 read request
- m0_write  in  1  master 0 write request
- m0_address  in  AW  master 0 address
- m0_dout  in  DW  master 0 write data
- m0_din  out  DW  master 0 read data, registered
- m0_ready  out  1  master 0 completion pulse
- m1_read, m1_write, m1_address, m1_dout, m1_din, m1_ready: identical for master 1
- ram_en  out  1  RAM access strobe
- ram_we  out  1  RAM write enable
- ram_addr  out  AW  RAM address
- ram_wdata  out  DW  RAM write data
- ram_rdata  in  DW  RAM read data
- grant  out  2  one-hot current owner; 00 when idle
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset is asynchronous and active-high, and can occur in any state. On reset:
  - state = IDLE
  - all outputs = 0, including m0_din, m1_din and grant
  - last_grant = 1, so m0 wins the first tie
  - latency counter = 0
  - A transaction in flight is abandoned with no ready pulse; the RAM sees no further strobe.
- A master request is pending when its read or write is high. If read and write are both high on the same master, the transaction is a write.
- States: IDLE, ACCESS, WAIT, RESP.
- IDLE:
  - Requests are sampled only in IDLE.
  - If both masters request, grant goes to the port that is not last_grant.
  - If one master requests, it is granted.
  - On a grant, latch the master's address, data and op into internal registers, set grant and last_grant, and go to ACCESS.
  - With no request, stay in IDLE.
- ACCESS:
  - Lasts exactly one cycle, with ram_en = 1, ram_we = op, ram_addr and ram_wdata taken from the latched values.
  - Write: go to RESP.
  - Read: load the counter with RD_LAT and go to WAIT.
- WAIT:
  - ram_en = 0; the counter decrements each cycle.
  - When the counter equals 1, capture ram_rdata into the granted master's din on that clock edge and go to RESP.
- RESP:
  - The granted master's ready = 1 for exactly one cycle; go to IDLE.
  - grant clears on entry to IDLE.
- Latency, counted from the first IDLE cycle where the request is seen (cycle 0):
  - Write: ram_en in cycle 1, ready in cycle 2.
  - Read: ram_en in cycle 1, data captured at the end of cycle 1+RD_LAT, ready in cycle 2+RD_LAT with din already valid.
- Master rule: a master drops or changes its request on the same edge at which it samples ready. There is therefore always at least one IDLE cycle between transactions.
- After grant, request inputs and data inputs are ignored. If a master deasserts mid-transaction, the transaction still completes and ready still pulses.
- din holds its value until the next read completion for that same port. The other port's din is never disturbed.
- The non-granted master sees ready = 0 throughout. Its request stays pending and is served next, which guarantees alternation under continuous contention.
- Outputs ram_en, ram_we, ram_addr, ram_wdata, ready and grant are all registered; there are no combinational paths from any input to any output.
- ram_addr and ram_wdata hold their last value when ram_en = 0.

Test Plan:
- Single write: m0_write = 1, m0_address = 0x10, m0_dout = 0xDEADBEEF. Expect ram_en = ram_we = 1 with addr 0x10 and data 0xDEADBEEF in cycle 1, m0_ready in cycle 2, m1_ready = 0 throughout.
- Single read (RD_LAT = 1): RAM model returns 0x12345678 at addr 0x20; m1_read = 1. Expect ram_en = 1, ram_we = 0 in cycle 1, m1_din = 0x12345678 and m1_ready = 1 in cycle 3, m0_din unchanged at 0.
- Contention: m0 and m1 both read continuously from reset. Grants are m0, m1, m0, m1; each ready pulses once per grant and IDLE appears between transactions.
- Latency (RD_LAT = 3): m0_read to addr 0x4. Expect m0_ready exactly in cycle 5 and a single ram_en pulse.
- Reset in WAIT (RD_LAT = 3): assert rst during WAIT. All outputs go to 0 immediately without a clock edge, with no ready pulse. After release, a m1 request is granted first.
- Read and write high together on m0: behaves as a write; m0_din is unchanged.

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM between two bus masters.
// Each granted transaction is sequenced IDLE -> ACCESS -> [WAIT] -> RESP to absorb the RAM read latency.
module mem_arbiter #(
    parameter int AW     = 32,
    parameter int DW     = 32,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_read,
    input  logic          m0_write,
    input  logic [AW-1:0] m0_address,
    input  logic [DW-1:0] m0_dout,
    output logic [DW-1:0] m0_din,
    output logic          m0_ready,
    input  logic          m1_read,
    input  logic          m1_write,
    input  logic [AW-1:0] m1_address,
    input  logic [DW-1:0] m1_dout,
    output logic [DW-1:0] m1_din,
    output logic          m1_ready,
    output logic          ram_en,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata,
    output logic [1:0]    grant,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

    state_t        state_q, state_d;
    logic          last_grant_q, last_grant_d;   // 1 = m1 was served last
    logic [1:0]    grant_q, grant_d;
    logic          op_q, op_d;                   // 1 = write
    logic [3:0]    cnt_q, cnt_d;
    logic          ram_en_q, ram_en_d;
    logic          ram_we_q, ram_we_d;
    logic [AW-1:0] ram_addr_q, ram_addr_d;
    logic [DW-1:0] ram_wdata_q, ram_wdata_d;
    logic          m0_ready_q, m0_ready_d;
    logic          m1_ready_q, m1_ready_d;
    logic [DW-1:0] m0_din_q, m0_din_d;
    logic [DW-1:0] m1_din_q, m1_din_d;

    logic req0, req1, pick1;

    assign req0  = m0_read | m0_write;
    assign req1  = m1_read | m1_write;
    // On a tie the port that was not served last wins.
    assign pick1 = req1 & (~req0 | ~last_grant_q);

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        op_d         = op_q;
        cnt_d        = cnt_q;
        ram_en_d     = 1'b0;
        ram_we_d     = 1'b0;
        ram_addr_d   = ram_addr_q;
        ram_wdata_d  = ram_wdata_q;
        m0_ready_d   = 1'b0;
        m1_ready_d   = 1'b0;
        m0_din_d     = m0_din_q;
        m1_din_d     = m1_din_q;

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    grant_d      = pick1 ? 2'b10 : 2'b01;
                    last_grant_d = pick1;
                    op_d         = pick1 ? m1_write : m0_write;
                    ram_addr_d   = pick1 ? m1_address : m0_address;
                    ram_wdata_d  = pick1 ? m1_dout : m0_dout;
                    ram_en_d     = 1'b1;
                    ram_we_d     = op_d;
                    state_d      = ACCESS;
                end
            end
            ACCESS: begin
                if (op_q) begin
                    m0_ready_d = grant_q[0];
                    m1_ready_d = grant_q[1];
                    state_d    = RESP;
                end else begin
                    cnt_d   = 4'(RD_LAT);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    if (grant_q[1]) m1_din_d = ram_rdata;
                    else            m0_din_d = ram_rdata;
                    m0_ready_d = grant_q[0];
                    m1_ready_d = grant_q[1];
                    state_d    = RESP;
                end
            end
            RESP: begin
                grant_d = 2'b00;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            grant_q      <= 2'b00;
            op_q         <= 1'b0;
            cnt_q        <= 4'd0;
            ram_en_q     <= 1'b0;
            ram_we_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
            m0_ready_q   <= 1'b0;
            m1_ready_q   <= 1'b0;
            m0_din_q     <= '0;
            m1_din_q     <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            op_q         <= op_d;
            cnt_q        <= cnt_d;
            ram_en_q     <= ram_en_d;
            ram_we_q     <= ram_we_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
            m0_ready_q   <= m0_ready_d;
            m1_ready_q   <= m1_ready_d;
            m0_din_q     <= m0_din_d;
            m1_din_q     <= m1_din_d;
        end
    end

    assign ram_en    = ram_en_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign m0_ready  = m0_ready_q;
    assign m1_ready  = m1_ready_q;
    assign m0_din    = m0_din_q;
    assign m1_din    = m1_din_q;
    assign grant     = grant_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (RD_LAT=1 and RD_LAT=3) share the master stimulus;
// expected completions go into a scoreboard queue and are popped when a ready pulse appears.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          m0_read = 1'b0, m0_write = 1'b0;
    logic [AW-1:0] m0_address = '0;
    logic [DW-1:0] m0_dout = '0;
    logic          m1_read = 1'b0, m1_write = 1'b0;
    logic [AW-1:0] m1_address = '0;
    logic [DW-1:0] m1_dout = '0;

    logic [DW-1:0] m0_din_a, m1_din_a, m0_din_b, m1_din_b;
    logic          m0_ready_a, m1_ready_a, m0_ready_b, m1_ready_b;
    logic          ram_en_a, ram_we_a, ram_en_b, ram_we_b;
    logic [AW-1:0] ram_addr_a, ram_addr_b;
    logic [DW-1:0] ram_wdata_a, ram_wdata_b;
    logic [DW-1:0] ram_rdata_a, ram_rdata_b, pipe1_b, pipe2_b;
    logic [1:0]    grant_a, grant_b;
    logic          busy_a, busy_b;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          port;
        bit          is_write;
        logic [31:0] data;
        int          ready_cyc;
    } exp_t;
    exp_t sb[$];

    mem_arbiter #(.AW(AW), .DW(DW), .RD_LAT(1)) dut_a (
        .clk(clk), .rst(rst),
        .m0_read(m0_read), .m0_write(m0_write), .m0_address(m0_address), .m0_dout(m0_dout),
        .m0_din(m0_din_a), .m0_ready(m0_ready_a),
        .m1_read(m1_read), .m1_write(m1_write), .m1_address(m1_address), .m1_dout(m1_dout),
        .m1_din(m1_din_a), .m1_ready(m1_ready_a),
        .ram_en(ram_en_a), .ram_we(ram_we_a), .ram_addr(ram_addr_a), .ram_wdata(ram_wdata_a),
        .ram_rdata(ram_rdata_a), .grant(grant_a), .busy(busy_a)
    );

    mem_arbiter #(.AW(AW), .DW(DW), .RD_LAT(3)) dut_b (
        .clk(clk), .rst(rst),
        .m0_read(m0_read), .m0_write(m0_write), .m0_address(m0_address), .m0_dout(m0_dout),
        .m0_din(m0_din_b), .m0_ready(m0_ready_b),
        .m1_read(m1_read), .m1_write(m1_write), .m1_address(m1_address), .m1_dout(m1_dout),
        .m1_din(m1_din_b), .m1_ready(m1_ready_b),
        .ram_en(ram_en_b), .ram_we(ram_we_b), .ram_addr(ram_addr_b), .ram_wdata(ram_wdata_b),
        .ram_rdata(ram_rdata_b), .grant(grant_b), .busy(busy_b)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return (a == 32'h20) ? 32'h1234_5678 : (a ^ 32'hC0DE_0000);
    endfunction

    // RAM models: read data is only valid exactly RD_LAT cycles after the strobe.
    always @(posedge clk) begin
        ram_rdata_a <= (ram_en_a && !ram_we_a) ? dflt(ram_addr_a) : 32'hBAD0_BAD0;
        pipe1_b     <= (ram_en_b && !ram_we_b) ? dflt(ram_addr_b) : 32'hBAD0_BAD0;
        pipe2_b     <= pipe1_b;
        ram_rdata_b <= pipe2_b;
    end

    function automatic logic get_rdy(input bit b, input bit p);
        return b ? (p ? m1_ready_b : m0_ready_b) : (p ? m1_ready_a : m0_ready_a);
    endfunction

    function automatic logic [31:0] get_din(input bit b, input bit p);
        return b ? (p ? m1_din_b : m0_din_b) : (p ? m1_din_a : m0_din_a);
    endfunction

    task automatic drop_all();
        m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
    endtask

    // One transaction on one port, tracked cycle by cycle on the selected instance.
    task automatic do_txn(input bit port, input bit rd, input bit wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input bit use_b, input string name);
        exp_t e;
        int lat, en_cnt, rdy_cnt;
        logic [31:0] other_before;
        logic en, we, busy;
        logic [31:0] addr_o, wdata_o;
        logic [1:0] grant_o;
        lat = use_b ? 3 : 1;
        e.port = port;
        e.is_write = wr;
        e.data = wr ? get_din(use_b, port) : dflt(addr);
        e.ready_cyc = wr ? 2 : 2 + lat;
        sb.push_back(e);
        other_before = get_din(use_b, !port);
        en_cnt = 0;
        rdy_cnt = 0;
        @(negedge clk);
        if (port) begin m1_read = rd; m1_write = wr; m1_address = addr; m1_dout = wdata; end
        else      begin m0_read = rd; m0_write = wr; m0_address = addr; m0_dout = wdata; end
        for (int c = 1; c <= e.ready_cyc + 3; c++) begin
            @(negedge clk);
            en      = use_b ? ram_en_b : ram_en_a;
            we      = use_b ? ram_we_b : ram_we_a;
            addr_o  = use_b ? ram_addr_b : ram_addr_a;
            wdata_o = use_b ? ram_wdata_b : ram_wdata_a;
            grant_o = use_b ? grant_b : grant_a;
            if (en) en_cnt++;
            if (c == 1) begin
                checks++;
                if (en !== 1'b1 || we !== wr) begin
                    errors++;
                    $display("FAIL %s access strobe: en=%b we=%b, required en=1 we=%b", name, en, we, wr);
                end
                checks++;
                if (addr_o !== addr) begin
                    errors++;
                    $display("FAIL %s ram_addr: got %h, required %h", name, addr_o, addr);
                end
                if (wr) begin
                    checks++;
                    if (wdata_o !== wdata) begin
                        errors++;
                        $display("FAIL %s ram_wdata: got %h, required %h", name, wdata_o, wdata);
                    end
                end
                checks++;
                if (grant_o !== (port ? 2'b10 : 2'b01)) begin
                    errors++;
                    $display("FAIL %s grant: got %b, required %b", name, grant_o, port ? 2'b10 : 2'b01);
                end
            end
            checks++;
            if (get_rdy(use_b, !port) !== 1'b0) begin
                errors++;
                $display("FAIL %s other ready at cycle %0d: got 1, required 0", name, c);
            end
            if (get_rdy(use_b, port) === 1'b1) begin
                rdy_cnt++;
                drop_all();
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL %s unexpected ready at cycle %0d, required none", name, c);
                end else begin
                    e = sb.pop_front();
                    if (c != e.ready_cyc) begin
                        errors++;
                        $display("FAIL %s ready cycle: got %0d, required %0d", name, c, e.ready_cyc);
                    end
                    checks++;
                    if (get_din(use_b, port) !== e.data) begin
                        errors++;
                        $display("FAIL %s din at ready: got %h, required %h", name, get_din(use_b, port), e.data);
                    end
                end
            end
        end
        drop_all();
        busy = use_b ? busy_b : busy_a;
        grant_o = use_b ? grant_b : grant_a;
        checks++;
        if (rdy_cnt != 1 || en_cnt != 1) begin
            errors++;
            $display("FAIL %s pulse counts: ready=%0d ram_en=%0d, required 1 and 1", name, rdy_cnt, en_cnt);
        end
        checks++;
        if (get_din(use_b, !port) !== other_before) begin
            errors++;
            $display("FAIL %s other din: got %h, required %h", name, get_din(use_b, !port), other_before);
        end
        checks++;
        if (busy !== 1'b0 || grant_o !== 2'b00) begin
            errors++;
            $display("FAIL %s back to idle: busy=%b grant=%b, required 0 and 00", name, busy, grant_o);
        end
        sb.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        checks++;
        if ({ram_en_a, ram_we_a, ram_addr_a, ram_wdata_a, grant_a, busy_a, m0_ready_a, m1_ready_a,
             m0_din_a, m1_din_a} !== '0) begin
            errors++;
            $display("FAIL reset_a outputs: got en=%b we=%b addr=%h wd=%h g=%b busy=%b rdy=%b%b din=%h/%h, required all 0",
                     ram_en_a, ram_we_a, ram_addr_a, ram_wdata_a, grant_a, busy_a, m0_ready_a, m1_ready_a, m0_din_a, m1_din_a);
        end
        checks++;
        if ({ram_en_b, ram_we_b, ram_addr_b, ram_wdata_b, grant_b, busy_b, m0_ready_b, m1_ready_b,
             m0_din_b, m1_din_b} !== '0) begin
            errors++;
            $display("FAIL reset_b outputs: got en=%b we=%b addr=%h wd=%h g=%b busy=%b rdy=%b%b din=%h/%h, required all 0",
                     ram_en_b, ram_we_b, ram_addr_b, ram_wdata_b, grant_b, busy_b, m0_ready_b, m1_ready_b, m0_din_b, m1_din_b);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single_write();
        do_txn(1'b0, 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, "single_write");
    endtask

    task automatic test_single_read();
        do_txn(1'b1, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, "single_read");
    endtask

    task automatic test_latency();
        do_txn(1'b0, 1'b1, 1'b0, 32'h4, 32'h0, 1'b1, "latency3");
    endtask

    task automatic test_rw_both();
        do_txn(1'b0, 1'b1, 1'b1, 32'h50, 32'hCAFE_F00D, 1'b0, "rw_both");
    endtask

    task automatic test_contention();
        exp_t e;
        int served, budget;
        bit idle_seen;
        logic p;
        rst = 1'b1;
        m0_read = 1; m0_address = 32'h30;
        m1_read = 1; m1_address = 32'h40;
        for (int i = 0; i < 4; i++) begin
            e.port = i[0];
            e.is_write = 1'b0;
            e.data = dflt(i[0] ? 32'h40 : 32'h30);
            e.ready_cyc = 0;
            sb.push_back(e);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        served = 0;
        budget = 0;
        idle_seen = 1'b1;
        while (served < 4 && budget < 60) begin
            @(negedge clk);
            budget++;
            if (!busy_a) idle_seen = 1'b1;
            if (m0_ready_a || m1_ready_a) begin
                p = m1_ready_a;
                e = sb.pop_front();
                served++;
                checks++;
                if ((m0_ready_a && m1_ready_a) || p !== e.port) begin
                    errors++;
                    $display("FAIL contention order #%0d: ready m0=%b m1=%b, required port %0d", served, m0_ready_a, m1_ready_a, e.port);
                end
                checks++;
                if (grant_a !== (e.port ? 2'b10 : 2'b01)) begin
                    errors++;
                    $display("FAIL contention grant #%0d: got %b, required %b", served, grant_a, e.port ? 2'b10 : 2'b01);
                end
                checks++;
                if (get_din(1'b0, e.port) !== e.data) begin
                    errors++;
                    $display("FAIL contention din #%0d: got %h, required %h", served, get_din(1'b0, e.port), e.data);
                end
                checks++;
                if (!idle_seen) begin
                    errors++;
                    $display("FAIL contention idle gap #%0d: got none, required at least one IDLE cycle", served);
                end
                idle_seen = 1'b0;
            end
        end
        checks++;
        if (served != 4) begin
            errors++;
            $display("FAIL contention timeout: served %0d, required 4", served);
        end
        drop_all();
        sb.delete();
        repeat (8) @(negedge clk);
    endtask

    task automatic test_reset_in_wait();
        @(negedge clk);
        m0_read = 1; m0_address = 32'h4;
        repeat (3) @(negedge clk);
        checks++;
        if (busy_b !== 1'b1 || ram_en_b !== 1'b0 || m0_ready_b !== 1'b0) begin
            errors++;
            $display("FAIL rst_wait precondition: busy=%b en=%b ready=%b, required 1 0 0", busy_b, ram_en_b, m0_ready_b);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({ram_en_b, ram_we_b, ram_addr_b, ram_wdata_b, grant_b, busy_b, m0_ready_b, m1_ready_b,
             m0_din_b, m1_din_b} !== '0) begin
            errors++;
            $display("FAIL rst_wait outputs: got en=%b we=%b addr=%h wd=%h g=%b busy=%b rdy=%b%b din=%h/%h, required all 0",
                     ram_en_b, ram_we_b, ram_addr_b, ram_wdata_b, grant_b, busy_b, m0_ready_b, m1_ready_b, m0_din_b, m1_din_b);
        end
        drop_all();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (m0_ready_b !== 1'b0 || m1_ready_b !== 1'b0 || ram_en_b !== 1'b0) begin
                errors++;
                $display("FAIL rst_wait held: ready=%b%b en=%b, required 0", m0_ready_b, m1_ready_b, ram_en_b);
            end
        end
        rst = 1'b0;
        do_txn(1'b1, 1'b1, 1'b0, 32'h24, 32'h0, 1'b1, "rst_then_m1");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        #1;
        test_reset();
        test_single_write();
        test_single_read();
        test_contention();
        test_latency();
        test_reset_in_wait();
        test_rw_both();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
